// File: rtl/uart_mem_dump.sv
// Streams n_words memory words to the UART transmitter, MSB byte first,
// optionally preceded by a word-count header byte so the host can verify a load.
module uart_mem_dump #(
    parameter int BYTE_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter bit SEND_HEADER = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [BYTE_WIDTH-1:0] i_n_words,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [BYTE_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        HDR_WAIT,
        FETCH,
        LATCH,
        SEND,
        WAIT_TX,
        DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BYTE_WIDTH-1:0] r_cnt;
    logic [BYTE_WIDTH-1:0] r_word_idx;
    logic [1:0]            r_byte_idx;
    logic [DATA_WIDTH-1:0] r_word;
    logic [BYTE_WIDTH:0]   w_word_idx_inc;
    logic                  w_more_words;

    assign w_word_idx_inc = {1'b0, r_word_idx} + {{BYTE_WIDTH{1'b0}}, 1'b1};
    assign w_more_words   = w_word_idx_inc < {1'b0, r_cnt};

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_addr     <= i_base_addr;
                        r_cnt      <= i_n_words;
                        r_word_idx <= '0;
                    end
                end
                LATCH: begin
                    r_word     <= i_rd_data;
                    r_byte_idx <= 2'd3;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        if (r_byte_idx != 2'd0) begin
                            r_byte_idx <= r_byte_idx - 2'd1;
                        end else if (w_more_words) begin
                            // address wraps naturally at 2^ADDR_WIDTH
                            r_addr     <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                            r_word_idx <= w_word_idx_inc[BYTE_WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        o_tx_start = 1'b0;
        o_tx_data  = '0;
        o_done     = 1'b0;
        o_busy     = (r_state != IDLE);
        o_rd_addr  = r_addr;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = SEND_HEADER ? HDR : FETCH;
                end
            end
            HDR: begin
                o_tx_data  = r_cnt;
                o_tx_start = 1'b1;
                w_next     = HDR_WAIT;
            end
            HDR_WAIT: begin
                o_tx_data = r_cnt;
                if (i_tx_done) begin
                    w_next = (r_cnt == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                // an empty headerless dump still spends one cycle here before DONE
                w_next = (r_cnt == '0) ? DONE : LATCH;
            end
            LATCH: begin
                w_next = SEND;
            end
            SEND: begin
                o_tx_data  = r_word[r_byte_idx*BYTE_WIDTH +: BYTE_WIDTH];
                o_tx_start = 1'b1;
                w_next     = WAIT_TX;
            end
            WAIT_TX: begin
                o_tx_data = r_word[r_byte_idx*BYTE_WIDTH +: BYTE_WIDTH];
                if (i_tx_done) begin
                    if (r_byte_idx != 2'd0) begin
                        w_next = SEND;
                    end else if (w_more_words) begin
                        w_next = FETCH;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_mem_dump.sv
// Directed bench: instance 0 sends a header byte, instance 1 does not; each has
// its own transmitter model that logs bytes and read addresses.
module tb_uart_mem_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n;
    logic [1:0]  start;
    logic [1:0]  tx_start;
    logic [1:0]  tx_done;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  inj_done;
    logic [7:0]  base_addr [2];
    logic [7:0]  n_words   [2];
    logic [7:0]  rd_addr   [2];
    logic [7:0]  tx_data   [2];
    logic [31:0] mem [256];
    int          tx_delay;
    int          total = 0;
    int          bad   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_d
        logic [31:0] rdd;
        logic        mdone;
        logic [7:0]  held;
        logic [7:0]  bq [$];
        logic [7:0]  aq [$];
        int          pend     = 0;
        int          extra    = 0;
        int          unstable = 0;
        int          ndone    = 0;

        uart_mem_dump #(
            .BYTE_WIDTH (8),
            .DATA_WIDTH (32),
            .ADDR_WIDTH (8),
            .SEND_HEADER(g == 0)
        ) u_dut (
            .i_clk      (clk),
            .i_arst_n   (arst_n),
            .i_start    (start[g]),
            .i_base_addr(base_addr[g]),
            .i_n_words  (n_words[g]),
            .o_rd_addr  (rd_addr[g]),
            .i_rd_data  (rdd),
            .o_tx_data  (tx_data[g]),
            .o_tx_start (tx_start[g]),
            .i_tx_done  (tx_done[g]),
            .o_busy     (busy[g]),
            .o_done     (done[g])
        );

        assign tx_done[g] = mdone | inj_done[g];

        always @(posedge clk) rdd <= mem[rd_addr[g]];

        always @(posedge clk) begin
            mdone <= 1'b0;
            if (done[g]) ndone++;
            if (!arst_n) begin
                pend = 0;
            end else if (tx_start[g]) begin
                if (pend != 0 || mdone) extra++;
                bq.push_back(tx_data[g]);
                aq.push_back(rd_addr[g]);
                held = tx_data[g];
                pend = tx_delay;
            end else if (pend != 0) begin
                if (tx_data[g] != held) unstable++;
                pend--;
                if (pend == 0) mdone <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lsize(input int d);
        return (d == 0) ? g_d[0].bq.size() : g_d[1].bq.size();
    endfunction

    function automatic logic [7:0] lbyte(input int d, input int k);
        if (k >= lsize(d)) return 8'hxx;
        return (d == 0) ? g_d[0].bq[k] : g_d[1].bq[k];
    endfunction

    function automatic logic [7:0] laddr(input int d, input int k);
        if (k >= lsize(d)) return 8'hxx;
        return (d == 0) ? g_d[0].aq[k] : g_d[1].aq[k];
    endfunction

    task automatic lclear(input int d);
        if (d == 0) begin
            g_d[0].bq.delete();
            g_d[0].aq.delete();
        end else begin
            g_d[1].bq.delete();
            g_d[1].aq.delete();
        end
    endtask

    task automatic kick(input int d, input logic [7:0] b, input logic [7:0] n);
        @(negedge clk);
        base_addr[d] = b;
        n_words[d]   = n;
        start[d]     = 1'b1;
        @(negedge clk);
        start[d]     = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        int c = 0;
        while (!done[d] && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("done_seen", {31'd0, done[d]}, 32'd1);
    endtask

    task automatic check_bytes(input string tag, input int d, input logic [71:0] exp, input int n);
        check({tag, "_count"}, lsize(d), n);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_byte%0d", tag, k), {24'd0, lbyte(d, k)}, {24'd0, exp[8*(n-1-k) +: 8]});
        end
    endtask

    initial begin
        int n0;
        int c;
        arst_n    = 1'b0;
        start     = 2'b00;
        inj_done  = 2'b00;
        tx_delay  = 3;
        for (int i = 0; i < 2; i++) begin
            base_addr[i] = 8'h00;
            n_words[i]   = 8'h00;
        end
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]   = 32'h11223344;
        mem[1]   = 32'hAABBCCDD;
        mem[2]   = 32'h55667788;
        mem[255] = 32'h01020304;

        repeat (3) @(negedge clk);
        check("rst_busy",     {30'd0, busy},     32'd0);
        check("rst_tx_start", {30'd0, tx_start}, 32'd0);
        check("rst_done",     {30'd0, done},     32'd0);
        check("rst_rd_addr",  {24'd0, rd_addr[0]}, 32'd0);
        check("rst_tx_data",  {24'd0, tx_data[0]}, 32'd0);
        arst_n = 1'b1;

        // header + two words
        kick(0, 8'h00, 8'd2);
        wait_done(0, 500);
        @(negedge clk);
        check("t1_busy_after", {31'd0, busy[0]}, 32'd0);
        check_bytes("t1", 0, 72'h02_1122_3344_AABB_CCDD, 9);
        check("t1_done_count", g_d[0].ndone, 1);

        // headerless, zero words
        kick(1, 8'h00, 8'd0);
        check("t2_c1_busy", {31'd0, busy[1]}, 32'd1);
        check("t2_c1_done", {31'd0, done[1]}, 32'd0);
        @(negedge clk);
        check("t2_c2_busy", {31'd0, busy[1]}, 32'd1);
        check("t2_c2_done", {31'd0, done[1]}, 32'd1);
        @(negedge clk);
        check("t2_c3_busy", {31'd0, busy[1]}, 32'd0);
        check("t2_c3_done", {31'd0, done[1]}, 32'd0);
        check("t2_no_bytes", lsize(1), 0);

        // address wrap, first tx_start timing
        lclear(1);
        kick(1, 8'hFF, 8'd2);
        check("t3_c1_rd_addr",  {24'd0, rd_addr[1]}, 32'hFF);
        check("t3_c1_tx_start", {31'd0, tx_start[1]}, 32'd0);
        @(negedge clk);
        check("t3_c2_tx_start", {31'd0, tx_start[1]}, 32'd0);
        @(negedge clk);
        check("t3_c3_tx_start", {31'd0, tx_start[1]}, 32'd1);
        check("t3_c3_tx_data",  {24'd0, tx_data[1]}, 32'h01);
        wait_done(1, 500);
        check_bytes("t3", 1, 72'h00_0102_0304_1122_3344, 8);
        check("t3_addr_w0", {24'd0, laddr(1, 0)}, 32'hFF);
        check("t3_addr_w1", {24'd0, laddr(1, 4)}, 32'h00);

        // start ignored mid-dump and in the DONE cycle
        lclear(0);
        n0 = g_d[0].ndone;
        kick(0, 8'h01, 8'd1);
        c = 0;
        while (lsize(0) < 2 && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("t4_progress", {31'd0, lsize(0) >= 2}, 32'd1);
        base_addr[0] = 8'h55;
        n_words[0]   = 8'd9;
        start[0]     = 1'b1;
        @(negedge clk);
        start[0]     = 1'b0;
        wait_done(0, 500);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check("t4_busy_after_done", {31'd0, busy[0]}, 32'd0);
        repeat (3) @(negedge clk);
        check("t4_still_idle", {31'd0, busy[0]}, 32'd0);
        check_bytes("t4", 0, 72'h00_0000_01AA_BBCC_DD, 5);
        check("t4_done_count", g_d[0].ndone - n0, 1);

        // reset during third byte's wait, then full dump
        lclear(1);
        kick(1, 8'h01, 8'd2);
        c = 0;
        while (lsize(1) < 3 && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("t5_progress", lsize(1), 3);
        arst_n = 1'b0;
        #1;
        check("t5_rst_busy",     {31'd0, busy[1]},     32'd0);
        check("t5_rst_tx_start", {31'd0, tx_start[1]}, 32'd0);
        check("t5_rst_tx_data",  {24'd0, tx_data[1]},  32'd0);
        check("t5_rst_rd_addr",  {24'd0, rd_addr[1]},  32'd0);
        check("t5_rst_done",     {31'd0, done[1]},     32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        lclear(1);
        kick(1, 8'h01, 8'd2);
        wait_done(1, 500);
        check_bytes("t5", 1, 72'h00_AABB_CCDD_5566_7788, 8);

        // slow transmitter, then stray tx_done in IDLE
        tx_delay = 100;
        lclear(0);
        kick(0, 8'h00, 8'd1);
        wait_done(0, 1000);
        check_bytes("t6", 0, 72'h00_0000_0111_2233_44, 5);
        check("t6_extra_start0", g_d[0].extra,    0);
        check("t6_unstable0",    g_d[0].unstable, 0);
        check("t6_extra_start1", g_d[1].extra,    0);
        check("t6_unstable1",    g_d[1].unstable, 0);
        lclear(0);
        lclear(1);
        @(negedge clk);
        inj_done = 2'b11;
        @(negedge clk);
        inj_done = 2'b00;
        repeat (5) @(negedge clk);
        check("t6_stray_busy", {30'd0, busy}, 32'd0);
        check("t6_stray_bytes0", lsize(0), 0);
        check("t6_stray_bytes1", lsize(1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
